// File: rtl/normalizer_seq.sv
// Multi-cycle left-normalizer: shifts an operand left one bit per cycle until its MSB is set,
// returning the normalized value and the negated shift count (the right shift that restores it).
module normalizer_seq #(
    parameter int BIT_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [BIT_COUNT-1:0] norm_in,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [BIT_COUNT-1:0] norm_out,
    output logic [BIT_COUNT-1:0] shift_amount,
    output logic                 zero
);

    localparam logic [BIT_COUNT-1:0] ONE = BIT_COUNT'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BIT_COUNT-1:0] work_reg;
    logic [BIT_COUNT-1:0] count_reg;
    logic                 work_zero;
    logic                 work_msb;

    assign work_zero   = (work_reg == '0);
    assign work_msb    = work_reg[BIT_COUNT-1];
    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = SHIFT;
            SHIFT:   if (work_zero || work_msb) state_next = DONE;
            DONE:    if (done_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result registers only load on the SHIFT->DONE decision, so the last result persists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg     <= '0;
            count_reg    <= '0;
            norm_out     <= '0;
            shift_amount <= '0;
            zero         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        work_reg  <= norm_in;
                        count_reg <= '0;
                    end
                end
                SHIFT: begin
                    if (work_zero) begin
                        zero         <= 1'b1;
                        norm_out     <= '0;
                        shift_amount <= '0;
                    end else if (work_msb) begin
                        zero         <= 1'b0;
                        norm_out     <= work_reg;
                        shift_amount <= '0 - count_reg;
                    end else begin
                        work_reg  <= {work_reg[BIT_COUNT-2:0], 1'b0};
                        count_reg <= count_reg + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalizer_seq.sv
// Self-checking bench for normalizer_seq: directed cases plus a shuffled sweep of all inputs
// compared against a leading-zero-count reference model.
module tb_normalizer_seq;

    localparam int W = 8;
    localparam int LIMIT = 2 * W + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] norm_in = '0;
    logic         done_valid;
    logic         done_ready = 1'b0;
    logic [W-1:0] norm_out;
    logic [W-1:0] shift_amount;
    logic         zero;

    int compared = 0;
    int mismatched = 0;

    normalizer_seq #(.BIT_COUNT(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .norm_in      (norm_in),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .norm_out     (norm_out),
        .shift_amount (shift_amount),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: leading zeros of a nonzero value; zero input counts as k=0.
    function automatic int lead_zeros(input logic [W-1:0] v);
        int k = 0;
        if (v == '0) return 0;
        while (v[W-1 - k] == 1'b0) k++;
        return k;
    endfunction

    // Barrel shifter the result feeds: signed amount, negative means shift right.
    function automatic logic [W-1:0] shifter(input logic [W-1:0] v, input logic [W-1:0] amt);
        int a = int'($signed(amt));
        if (a < 0) return v >> (-a);
        return v << a;
    endfunction

    // Waits (bounded) for done_valid after the accept edge; returns the edge count.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < LIMIT) begin
            @(posedge clk);
            cycles++;
            #1;
            if (done_valid) break;
        end
    endtask

    task automatic run_op(input logic [W-1:0] val, input int hold, input string tag);
        int cycles;
        int k = lead_zeros(val);
        logic [W-1:0] exp_norm = (val == '0) ? '0 : W'(val << k);
        logic [W-1:0] exp_shift = W'(-k);
        check({tag, ".start_ready"}, start_ready, 1);
        norm_in = val;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_done(cycles);
        check({tag, ".latency"}, cycles, k + 1);
        check({tag, ".norm_out"}, norm_out, exp_norm);
        check({tag, ".shift_amount"}, shift_amount, exp_shift);
        check({tag, ".zero"}, zero, val == '0);
        if (val != '0) check({tag, ".roundtrip"}, shifter(norm_out, shift_amount), val);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) check({tag, ".held_valid"}, done_valid, 1);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        check({tag, ".idle_ready"}, {done_valid, start_ready}, 2'b01);
        check({tag, ".persist"}, norm_out, exp_norm);
    endtask

    initial begin
        int cycles;
        logic seen;
        logic [W-1:0] order [256];

        // Reset state
        #12;
        check("reset.outputs", {norm_out, shift_amount, zero}, '0);
        check("reset.handshake", {start_ready, done_valid}, 2'b10);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases: deepest shift, already normalized, zero
        run_op(8'h01, 0, "t1");
        run_op(8'h80, 0, "t2");
        run_op(8'h00, 0, "t3");

        // Back-pressure with start_valid held high on a different operand
        norm_in = 8'h13;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        norm_in = 8'hFF;
        wait_done(cycles);
        check("t4.latency", cycles, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t4.hold", {norm_out, shift_amount, zero, start_ready, done_valid},
                  {8'h98, 8'hFD, 1'b0, 1'b0, 1'b1});
        end
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        check("t4.idle", {start_ready, done_valid, norm_out}, {1'b1, 1'b0, 8'h98});
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check("t4.accept_ff", start_ready, 0);
        @(posedge clk);
        #1;
        check("t4.ff_result", {done_valid, norm_out, shift_amount, zero},
              {1'b1, 8'hFF, 8'h00, 1'b0});
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;

        // Reset mid-SHIFT discards the pending result
        norm_in = 8'h01;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5.reset_outputs", {norm_out, shift_amount, zero}, '0);
        check("t5.reset_handshake", {start_ready, done_valid}, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= done_valid;
        end
        check("t5.no_done", seen, 0);
        run_op(8'h40, 0, "t5b");

        // Shuffled sweep of every input with random consumer stalls
        for (int i = 0; i < 256; i++) order[i] = W'(i);
        for (int i = 255; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            logic [W-1:0] t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            run_op(order[i], $urandom_range(2, 0), $sformatf("sweep_%02h", order[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
